unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the fetch stage (IF port) and the
//  memory stage (D port) of the 5-stage pipeline. Serialises accesses with a small FSM and returns
//  read data with a one-cycle ack. Drives stall_if and stall_mem so that the PC, IF/ID and later
//  pipeline registers hold while their access is outstanding.
// PARAMETERS
//  ADDR_W       64  address width, both ports and memory side
//  DATA_W       64  memory word width; IF port returns bits [31:0]
//  MEM_LATENCY  2   cycles from the mem_req cycle to mem_rdata valid (>=1)
//  STARVE_LIMIT 4   consecutive D grants, with if_req pending, before IF is forced through (>=1)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high
//  if_req     in   1       fetch request; held high until if_ack
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_rdata   out  32      instruction; valid in the if_ack cycle, held until the next if_ack
//  if_ack     out  1       one-cycle completion pulse for the IF port
//  d_req      in   1       data request; held high until d_ack
//  d_we       in   1       1=write, 0=read
//  d_addr     in   ADDR_W  data address (EX/MEM ALU result)
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data; valid in the d_ack cycle, held until the next read d_ack
//  d_ack      out  1       one-cycle completion pulse for the D port
//  mem_req    out  1       one-cycle access strobe to memory
//  mem_we     out  1       write enable, valid with mem_req
//  mem_addr   out  ADDR_W  registered address, stable from mem_req until ack
//  mem_wdata  out  DATA_W  registered write data, stable from mem_req until ack
//  mem_rdata  in   DATA_W  memory read data, valid exactly MEM_LATENCY cycles after the mem_req cycle
//  stall_if   out  1       if_req & ~if_ack (combinational)
//  stall_mem  out  1       d_req & ~d_ack (combinational)
// BEHAVIOUR
//  - States: IDLE, BUSY_IF, BUSY_D, DONE. Reset: IDLE; all outputs 0; if_rdata/d_rdata 0; counters 0.
//  - IDLE: if there is any request, capture the winner's addr/we/wdata into mem_* regs and go to BUSY_x.
//    Set cnt=MEM_LATENCY. With no request, stay in IDLE.
//  - Arbitration in IDLE: only one request wins that request. If both request, D wins unless
//    starve_cnt==STARVE_LIMIT, in which case IF wins.
//  - starve_cnt: +1 on a D grant while if_req=1 (saturates at STARVE_LIMIT). Cleared on an IF grant
//    or when if_req=0 in IDLE.
//  - BUSY_x: mem_req=1 only in the first BUSY cycle; mem_we=captured we in that cycle, else 0.
//    cnt decrements every cycle. At cnt==1, sample mem_rdata on the edge and go to DONE.
//  - DONE (one cycle): x_ack=1. Reads load x_rdata. Writes leave d_rdata unchanged and never produce
//    an IF write. No grant is issued in DONE. Next state is IDLE.
//  - Latency: req seen in IDLE cycle t -> mem_req at t+1 -> ack at t+MEM_LATENCY+2.
//    Back-to-back throughput is one access per MEM_LATENCY+3 cycles.
//  - Inputs are sampled only at grant. Changes to addr, we or wdata after grant are ignored.
//  - A request dropped before its ack is a protocol violation. The access still completes and the ack
//    still pulses; the ack is ignored by the requester.
//  - Reset mid-access: return to IDLE next cycle, mem_req=0, ack is not issued, and the in-flight
//    mem_rdata is discarded.
//  - mem_addr and mem_wdata hold their last values in IDLE. mem_we=0 whenever mem_req=0.
// TESTING
//  1. MEM_LATENCY=2. if_req at t0, addr=0x10, mem_rdata=0x00000000_00A00093 at t3 -> mem_req at t1;
//     if_ack at t4; if_rdata=0x00A00093; stall_if high t0..t3.
//  2. if_req and d_req (read, 0x80) both at t0 -> D is served first (d_ack at t4); IF is granted at t5
//     (mem_req t6, if_ack t9).
//  3. d_req with d_we=1, addr=0x40, wdata=0xDEAD -> mem_req=mem_we=1 for one cycle with
//     mem_addr=0x40, mem_wdata=0xDEAD; d_ack pulses; d_rdata unchanged.
//  4. STARVE_LIMIT=2, d_req held high continuously, if_req held high -> grant order D, D, IF, D, D, IF.
//  5. reset asserted during BUSY_D with cnt==1 -> next cycle IDLE, no d_ack, all outputs 0.
//  6. d_addr changed after grant -> mem_addr keeps the originally captured value until d_ack.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the fetch (IF) and data (D) ports.
// One access is in flight at a time; D has priority unless IF has been starved STARVE_LIMIT times.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CntW    = $clog2(MEM_LATENCY + 2);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  // The busy window spans the strobe cycle plus MEM_LATENCY cycles; data is sampled when cnt is 1.
  localparam logic [CntW-1:0]    CntLoad   = CntW'(MEM_LATENCY + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                owner_d_q, owner_d_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_if, grant_d;
  logic                busy;

  assign busy = (state_q == StBusyIf) || (state_q == StBusyD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    owner_d_d  = owner_d_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_if   = 1'b0;
    grant_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (d_req && !(if_req && starve_q == StarveMax)) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end

        if (grant_d) begin
          state_d   = StBusyD;
          cnt_d     = CntLoad;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          we_d      = d_we;
          owner_d_d = 1'b1;
          if (if_req && starve_q != StarveMax) begin
            starve_d = starve_q + StarveW'(1);
          end
        end else if (grant_if) begin
          state_d   = StBusyIf;
          cnt_d     = CntLoad;
          addr_d    = if_addr;
          we_d      = 1'b0;
          owner_d_d = 1'b0;
          starve_d  = '0;
        end

        if (!if_req) begin
          starve_d = '0;
        end
      end

      StBusyIf, StBusyD: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          if (state_q == StBusyIf) begin
            if_rdata_d = mem_rdata[31:0];
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_d_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      owner_d_q  <= owner_d_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req   = busy && (cnt_q == CntLoad);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == StDone) & ~owner_d_q;
  assign d_ack     = (state_q == StDone) & owner_d_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table, per-port scoreboards and a
// behavioural fixed-latency memory.
module tb_unified_mem_arbiter;

  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned LAT = 2;
  localparam int unsigned SL  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_if (stall_if),
    .stall_mem(stall_mem)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h10) return 64'h00000000_00A00093;
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  // Memory returns data exactly LAT cycles after the strobe cycle, garbage otherwise.
  logic [63:0] pend_addr = '0;
  int          pend_cnt  = 0;
  always @(posedge clk) begin
    if (mem_req) begin
      pend_addr <= mem_addr;
      pend_cnt  <= LAT;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end
  assign mem_rdata = (pend_cnt == 1) ? mem_word(pend_addr) : 64'hDEAD_BEEF_0BAD_F00D;

  logic [31:0] if_exp_q[$];
  logic [63:0] d_exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (if_ack) begin
        if (if_exp_q.size() == 0) check_bit("if_ack_unexpected", if_ack, 1'b0);
        else check_val("if_rdata", 64'(if_rdata), 64'(if_exp_q.pop_front()));
      end
      if (d_ack) begin
        if (d_exp_q.size() == 0) check_bit("d_ack_unexpected", d_ack, 1'b0);
        else check_val("d_rdata", d_rdata, d_exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int          n;
    logic        ack;
    logic [63:0] a;
    a = v.addr;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = a; d_wdata = v.wdata;
      d_exp_q.push_back(v.exp_rdata);
    end else begin
      if_req = 1'b1; if_addr = a;
      if_exp_q.push_back(v.exp_rdata[31:0]);
    end
    #1;
    check_bit("stall_t0", v.is_d ? stall_mem : stall_if, 1'b1);
    n = 0;
    ack = 1'b0;
    while (!ack && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        check_bit("mem_req_strobe", mem_req, 1'b1);
        check_bit("mem_we_strobe", mem_we, v.we);
        if (v.we) check_val("mem_wdata", mem_wdata, v.wdata);
        // Later changes to the port inputs must not reach the memory side.
        d_addr = ~a; d_wdata = ~v.wdata; d_we = ~v.we; if_addr = ~a;
      end else if (n == 2) begin
        check_bit("mem_req_single", mem_req, 1'b0);
        check_bit("mem_we_low", mem_we, 1'b0);
      end
      check_val("mem_addr_hold", mem_addr, a);
      ack = v.is_d ? d_ack : if_ack;
      if (!ack) check_bit("stall_busy", v.is_d ? stall_mem : stall_if, 1'b1);
    end
    check_val("ack_latency", 64'(n), 64'(LAT + 2));
    check_bit("stall_at_ack", v.is_d ? stall_mem : stall_if, 1'b0);
    check_bit("other_ack_quiet", v.is_d ? if_ack : d_ack, 1'b0);
    d_req = 1'b0; if_req = 1'b0;
    tick();
    check_bit("ack_one_cycle", v.is_d ? d_ack : if_ack, 1'b0);
  endtask

  vec_t        vecs[6];
  int          n, mr_cnt, mr1, mr2, d_at, i_at, grants, k_d, k_i;
  logic [5:0]  order;
  logic [63:0] w;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_bit("rst_mem_req", mem_req, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    check_bit("rst_if_ack", if_ack, 1'b0);
    check_bit("rst_d_ack", d_ack, 1'b0);
    check_val("rst_mem_addr", mem_addr, 64'h0);
    check_val("rst_mem_wdata", mem_wdata, 64'h0);
    check_val("rst_if_rdata", 64'(if_rdata), 64'h0);
    check_val("rst_d_rdata", d_rdata, 64'h0);

    vecs[0] = '{1'b0, 1'b0, 64'h10, 64'h0, 64'h00A00093};
    vecs[1] = '{1'b1, 1'b0, 64'h80, 64'h0, mem_word(64'h80)};
    vecs[2] = '{1'b1, 1'b1, 64'h40, 64'hDEAD, mem_word(64'h80)};
    vecs[3] = '{1'b0, 1'b0, 64'h1234, 64'h0, mem_word(64'h1234)};
    vecs[4] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, mem_word(64'hFFFF_FFFF_FFFF_FFF8)};
    vecs[5] = '{1'b1, 1'b1, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, mem_word(64'hFFFF_FFFF_FFFF_FFF8)};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous requests: D first, IF granted right after D's DONE cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h80; if_req = 1'b1; if_addr = 64'h20;
    d_exp_q.push_back(mem_word(64'h80));
    w = mem_word(64'h20);
    if_exp_q.push_back(w[31:0]);
    n = 0; mr_cnt = 0; mr1 = -1; mr2 = -1; d_at = -1; i_at = -1;
    while ((d_req || if_req) && n < 30) begin
      tick();
      n++;
      if (mem_req) begin
        if (mr_cnt == 0) mr1 = n;
        else mr2 = n;
        mr_cnt++;
      end
      if (d_ack) begin d_at = n; d_req = 1'b0; end
      if (if_ack) begin i_at = n; if_req = 1'b0; end
    end
    check_val("both_d_strobe", 64'(mr1), 64'd1);
    check_val("both_d_ack", 64'(d_at), 64'd4);
    check_val("both_if_strobe", 64'(mr2), 64'd6);
    check_val("both_if_ack", 64'(i_at), 64'd9);
    tick();

    // Starvation guard: with both ports saturating, IF gets every third grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100; if_req = 1'b1; if_addr = 64'h200;
    d_exp_q.push_back(mem_word(64'h100));
    w = mem_word(64'h200);
    if_exp_q.push_back(w[31:0]);
    k_d = 1; k_i = 1; grants = 0; order = '0; n = 0;
    while ((d_req || if_req) && n < 200) begin
      tick();
      n++;
      if (mem_req) begin
        if (grants < 6) order[grants] = (mem_addr[9:8] == 2'b10);
        grants++;
      end
      if (d_ack) begin
        if (grants < 6) begin
          d_addr = 64'h100 + 64'(k_d); k_d++;
          d_exp_q.push_back(mem_word(d_addr));
        end else d_req = 1'b0;
      end
      if (if_ack) begin
        if (grants < 6) begin
          if_addr = 64'h200 + 64'(k_i); k_i++;
          w = mem_word(if_addr);
          if_exp_q.push_back(w[31:0]);
        end else if_req = 1'b0;
      end
    end
    check_val("grant_order", 64'(order), 64'(6'b100100));
    check_bit("starve_drained", d_req | if_req, 1'b0);
    tick();

    // Reset while the D access sits in its sampling cycle: access is dropped silently.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    repeat (3) tick();
    reset = 1'b1; d_req = 1'b0;
    tick();
    check_bit("rstmid_d_ack", d_ack, 1'b0);
    check_bit("rstmid_mem_req", mem_req, 1'b0);
    check_bit("rstmid_mem_we", mem_we, 1'b0);
    check_val("rstmid_mem_addr", mem_addr, 64'h0);
    check_val("rstmid_d_rdata", d_rdata, 64'h0);
    check_val("rstmid_if_rdata", 64'(if_rdata), 64'h0);
    reset = 1'b0;
    tick();
    check_bit("rstmid_no_late_ack", d_ack, 1'b0);
    check_bit("rstmid_idle", mem_req, 1'b0);

    run_vec(vecs[1]);

    check_val("sb_if_drain", 64'(if_exp_q.size()), 64'h0);
    check_val("sb_d_drain", 64'(d_exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
